// File: rtl/scalar_mult_seq.sv
// Time-multiplexed vector-by-scalar fixed-point multiplier: one shared pipelined
// multiplier is sequenced over up to NUM_ELEM elements with a start/busy/done handshake.
`ifndef MAX_NEURONS
`define MAX_NEURONS 8
`endif

module scalar_mult_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module scalar_mult_seq #(
  parameter int NUM_ELEM = `MAX_NEURONS,
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int LEN_W    = $clog2(NUM_ELEM+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [LEN_W-1:0]               len,
  input  logic [NUM_ELEM-1:0][WIDTH-1:0] vec_in,
  input  logic [WIDTH-1:0]               scalar,
  output logic [NUM_ELEM-1:0][WIDTH-1:0] out_vec,
  output logic                           busy,
  output logic                           done,
  output logic                           ovf
);
  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int PW    = 2*WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                         state;
  logic [NUM_ELEM-1:0][WIDTH-1:0] vec_q;
  logic [WIDTH-1:0]               scal_q;
  logic [LEN_W-1:0]               len_q, len_clamp;
  logic [IDX_W-1:0]               idx, tag;
  logic                           pv;
  logic signed [PW-1:0]           prod, a_ext, b_ext, shifted;
  logic                           sat;
  logic [WIDTH-1:0]               wb_data;
  logic                           clr;

  assign len_clamp = (len > LEN_W'(NUM_ELEM)) ? LEN_W'(NUM_ELEM) : len;
  assign clr       = (state == IDLE) && start;

  assign a_ext = {{WIDTH{vec_q[idx][WIDTH-1]}}, vec_q[idx]};
  assign b_ext = {{WIDTH{scal_q[WIDTH-1]}}, scal_q};

  // Floor shift, then saturate whenever the upper bits are not a pure sign extension.
  assign shifted = prod >>> FRAC;
  assign sat     = (|shifted[PW-1:WIDTH-1]) & ~(&shifted[PW-1:WIDTH-1]);
  assign wb_data = sat ? (shifted[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}})
                       : shifted[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      idx    <= '0;
      tag    <= '0;
      pv     <= 1'b0;
      prod   <= '0;
      vec_q  <= '0;
      scal_q <= '0;
      len_q  <= '0;
    end else begin
      done <= 1'b0;
      pv   <= 1'b0;
      if (pv) ovf <= ovf | sat;
      case (state)
        IDLE: if (start) begin
          vec_q  <= vec_in;
          scal_q <= scalar;
          len_q  <= len_clamp;
          idx    <= '0;
          ovf    <= 1'b0;
          busy   <= 1'b1;
          if (len_clamp == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          prod <= a_ext * b_ext;
          tag  <= idx;
          pv   <= 1'b1;
          idx  <= idx + IDX_W'(1);
          if (LEN_W'(idx) == len_q - LEN_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_lane
    scalar_mult_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .we    (pv && (tag == IDX_W'(i))),
      .d     (wb_data),
      .q     (out_vec[i])
    );
  end
endmodule

// File: doc/scalar_mult_seq.md
# scalar_mult_seq

Time-multiplexed controller for vector-by-scalar fixed-point multiplication. It replaces the fully parallel `MAX_NEURONS`-wide multiplier bank with a single shared, pipelined multiplier. A start/busy/done handshake sequences it over up to `NUM_ELEM` elements. It sits between the layer sequencer (e.g. learning-rate scaling of gradient vectors) and the vector register file, trading latency for area.

## Interface
- `NUM_ELEM`, default `` `MAX_NEURONS ``: vector length (elements per ARR).
- `WIDTH`, default 32: element width, two's-complement fixed point (`data`).
- `FRAC`, default 16: fractional bits.
- `LEN_W`, default `$clog2(NUM_ELEM+1)`: width of `len`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted only when `busy`=0.
- `len`  in  LEN_W  number of elements to process; sampled at accept.
- `vec_in`  in  NUM_ELEM×WIDTH (ARR)  operand vector; sampled at accept.
- `scalar`  in  WIDTH (data)  scalar operand; sampled at accept.
- `out_vec`  out  NUM_ELEM×WIDTH (ARR)  registered result vector.
- `busy`  out  1  operation in progress, including the DONE cycle.
- `done`  out  1  single-cycle completion pulse.
- `ovf`  out  1  sticky: at least one element saturated in the current/last operation.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **Accept** (IDLE && `start`):
  - latch `vec_in`, `scalar`, and `len` clamped to NUM_ELEM (`len`>NUM_ELEM → NUM_ELEM);
  - clear `out_vec` to all zero and clear `ovf`;
  - set `idx`=0;
  - next state: RUN, or DONE if clamped len=0.
- **RUN**:
  - each cycle, issue element `idx` to the multiplier stage: product register ← latched `vec[idx]` × scalar (2·WIDTH signed), tagged with `idx` and valid=1;
  - `idx`++;
  - after issuing `idx`=len−1 → DRAIN.
- **Writeback**: every cycle the product register is valid, `out_vec[tag]` ← sat(product >>> FRAC), and `ovf` |= saturated.
- **DRAIN**: no issue; last writeback completes → DONE.
- **DONE**: `done`=1 for one cycle → IDLE.
- **Arithmetic**:
  - arithmetic right shift by FRAC, i.e. floor, no rounding;
  - saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1];
  - saturated means the shifted value lies outside that range.
- Elements with index ≥ len read 0 in `out_vec`.
- `start` in any state other than IDLE is ignored; it is not queued.
- Input changes while `busy`=1 have no effect.
- `out_vec` and `ovf` hold their final values after DONE until the next accept.

## Timing
- **Reset**:
  - asynchronous, effective immediately on `rst_n`=0;
  - state=IDLE, `out_vec`=0, `busy`=0, `done`=0, `ovf`=0, `idx`=0, product valid=0.
- Reset mid-operation aborts the operation: no `done` pulse, outputs take their reset values.
- **Accept cycle** c0: `busy` rises at c1.
- **Element issue**: element k is issued in cycle c(1+k) and written to `out_vec` at the end of cycle c(2+k).
- **Completion**:
  - DRAIN occupies cycle c(len+1);
  - `done`=1 in cycle c(len+2), with `out_vec` and `ovf` final in that cycle;
  - `busy`=0 from c(len+3).
- **len=0**: `done`=1 in c1, `out_vec`=0, `ovf`=0.
- **Throughput**: one element per cycle. Back-to-back: the earliest next accept is cycle c(len+3), i.e. `start` held high is accepted in the first IDLE cycle.
- `busy` and `done` are registered, with no combinational path from inputs.

## Test plan
- Reset values: assert `rst_n`=0 mid-RUN (len=8) → `busy`, `done`, `ovf`=0, `out_vec`=0 immediately; no `done` after release.
- Basic, WIDTH=32, FRAC=16: len=2, vec={0x00018000, 0xFFFF0000}, scalar=0x00020000:
  - `out_vec`={0x00030000, 0xFFFE0000}, remaining elements 0, `ovf`=0;
  - `done` exactly 4 cycles after the accept cycle.
- Saturation and floor: len=3, vec={0x40000000, 0xC0000000, 0xFFFFFFFF}, scalar=0x00040000:
  - element 0 → 0x7FFFFFFF;
  - element 1 → 0x80000000;
  - element 2 → 0xFFFFFFFC;
  - `ovf`=1.
  - Separately, 0xFFFFFFFF × 0x00008000 → 0xFFFFFFFF (floor).
- len boundaries:
  - len=0 → `done` at c1, `out_vec` all zero;
  - len=NUM_ELEM+5 → clamped; all NUM_ELEM elements computed; `done` at c(NUM_ELEM+2).
- Handshake:
  - `start` and changed `vec_in`/`scalar` pulsed during RUN → ignored; results reflect the accept-time operands;
  - `start` held high continuously → operations accepted every len+3 cycles, one `done` each;
  - `ovf` cleared on each accept.
